// File: rtl/branch_ckpt_stack.sv
// Branch checkpoint stack: one slot per in-flight branch holding the rename
// map table, free-list head and the mask of older live branches it depends on.
// Optional free-slot counter output is enabled by defining BR_STACK_CNT_EN.
module branch_ckpt_stack #(
  parameter int BR_DEPTH  = 4,
  parameter int MT_NUM    = 32,
  parameter int PRF_IDX_W = 6,
  parameter int FL_PTR_W  = 5
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                is_br_i,
  input  logic [1:0]                          br_state_i,
  input  logic [BR_DEPTH-1:0]                 br_tag_i,
  input  logic [MT_NUM*(PRF_IDX_W+1)-1:0]     bak_mt_data_i,
  input  logic [FL_PTR_W-1:0]                 bak_fl_head_i,
  output logic [BR_DEPTH-1:0]                 br_mask_o,
  output logic [BR_DEPTH-1:0]                 br_tag_o,
  output logic [BR_DEPTH-1:0]                 br_bit_o,
  output logic [BR_DEPTH-1:0]                 squash_mask_o,
  output logic                                full_o,
  output logic [MT_NUM*(PRF_IDX_W+1)-1:0]     rc_mt_data_o,
`ifdef BR_STACK_CNT_EN
  output logic [$clog2(BR_DEPTH+1)-1:0]       br_free_cnt_o,
`endif
  output logic [FL_PTR_W-1:0]                 rc_fl_head_o
);

  localparam int MT_W  = MT_NUM * (PRF_IDX_W + 1);
  localparam int CNT_W = $clog2(BR_DEPTH + 1);

  localparam logic [1:0] ST_CORRECT = 2'b01;
  localparam logic [1:0] ST_WRONG   = 2'b10;

  logic [BR_DEPTH-1:0] r_valid;
  logic [BR_DEPTH-1:0] r_dep [BR_DEPTH];
  logic [MT_W-1:0]     r_mt  [BR_DEPTH];
  logic [FL_PTR_W-1:0] r_fl  [BR_DEPTH];

  logic                w_accept;
  logic                w_correct;
  logic                w_wrong;
  logic [BR_DEPTH-1:0] w_kill;
  logic [BR_DEPTH-1:0] w_squash;
  logic [BR_DEPTH-1:0] w_clr;
  logic [BR_DEPTH-1:0] w_valid_post;
  logic [BR_DEPTH-1:0] w_valid_next;
  logic [BR_DEPTH-1:0] w_alloc;
  logic [BR_DEPTH-1:0] w_grant;
  logic                w_found;
  logic [MT_W-1:0]     w_sel_mt;
  logic [FL_PTR_W-1:0] w_sel_fl;

  assign w_accept  = ((br_state_i == ST_CORRECT) || (br_state_i == ST_WRONG)) &&
                     (|(br_tag_i & r_valid));
  assign w_correct = w_accept && (br_state_i == ST_CORRECT);
  assign w_wrong   = w_accept && (br_state_i == ST_WRONG);

  // Slot snapshot select and younger-slot kill set, both driven by the one-hot tag.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_sel_mt = '0;
    w_sel_fl = '0;
    w_kill   = '0;
    for (int i = 0; i < BR_DEPTH; i++) begin
      if (br_tag_i[i]) begin
        w_sel_mt = w_sel_mt | r_mt[i];
        w_sel_fl = w_sel_fl | r_fl[i];
      end
      w_kill[i] = r_valid[i] && (|(r_dep[i] & br_tag_i));
    end
  end

  assign w_squash     = w_wrong ? (w_kill | br_tag_i) : '0;
  assign w_clr        = w_correct ? br_tag_i : w_squash;
  assign w_valid_post = r_valid & ~w_clr;

  always_comb begin
    w_alloc = '0;
    w_found = 1'b0;
    for (int i = 0; i < BR_DEPTH; i++) begin
      if (!w_valid_post[i] && !w_found) begin
        w_alloc[i] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

  assign w_grant      = (is_br_i && !w_wrong) ? w_alloc : '0;
  assign w_valid_next = w_valid_post | w_grant;

  assign br_mask_o     = r_valid;
  assign br_tag_o      = w_grant;
  assign br_bit_o      = w_accept ? br_tag_i : '0;
  assign squash_mask_o = w_squash;
  assign full_o        = &w_valid_post;
  assign rc_mt_data_o  = w_wrong ? w_sel_mt : '0;
  assign rc_fl_head_o  = w_wrong ? w_sel_fl : '0;

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < BR_DEPTH; i++) r_dep[i] <= '0;
    end else begin
      r_valid <= w_valid_next;
      for (int i = 0; i < BR_DEPTH; i++) begin
        if (w_grant[i]) r_dep[i] <= w_valid_post;
        else            r_dep[i] <= r_dep[i] & ~w_clr;
      end
    end
  end

  // NOTE: snapshot storage has no reset; a slot is only read after it was written.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BR_DEPTH; i++) begin
      if (w_grant[i]) begin
        r_mt[i] <= bak_mt_data_i;
        r_fl[i] <= bak_fl_head_i;
      end
    end
  end

`ifdef BR_STACK_CNT_EN
  logic [CNT_W-1:0] r_free_cnt;
  logic [CNT_W-1:0] w_free_next;

  always_comb begin
    w_free_next = '0;
    for (int i = 0; i < BR_DEPTH; i++)
      w_free_next = w_free_next + {{(CNT_W-1){1'b0}}, ~w_valid_next[i]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_free_cnt <= CNT_W'(BR_DEPTH);
    else        r_free_cnt <= w_free_next;
  end

  assign br_free_cnt_o = r_free_cnt;
`endif

endmodule

// File: doc/branch_ckpt_stack.md
BRANCH_CKPT_STACK -- requirements
Module: branch_ckpt_stack

Interface
REQ-001 SHALL have parameter BR_DEPTH, default 4: number of checkpoint slots and branch-mask width (2..16).
REQ-002 SHALL have parameter MT_NUM, default 32: map-table entries per snapshot.
REQ-003 SHALL have parameter PRF_IDX_W, default 6: each snapshot entry is PRF_IDX_W+1 bits (tag plus ready bit).
REQ-004 SHALL have parameter FL_PTR_W, default 5: free-list head width.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 Ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- is_br_i  in  1  dispatch of a new branch this cycle.
- br_state_i  in  2  resolution: 00 none, 01 correct, 10 wrong; 11 treated as none.
- br_tag_i  in  BR_DEPTH  one-hot slot of the resolving branch.
- bak_mt_data_i  in  MT_NUM*(PRF_IDX_W+1)  map-table state to checkpoint.
- bak_fl_head_i  in  FL_PTR_W  free-list head to checkpoint.
- br_mask_o  out  BR_DEPTH  current mask of live branches.
- br_tag_o  out  BR_DEPTH  one-hot slot granted to this cycle's dispatch; 0 if none.
- br_bit_o  out  BR_DEPTH  equals br_tag_i when the resolution is accepted, else 0.
- squash_mask_o  out  BR_DEPTH  on accepted wrong: the slots killed (resolved slot plus all younger); else 0.
- full_o  out  1  no free slot after this cycle's resolution.
- rc_mt_data_o  out  MT_NUM*(PRF_IDX_W+1)  recovery map-table snapshot.
- rc_fl_head_o  out  FL_PTR_W  recovery free-list head.

Function
REQ-007 Each slot SHALL hold valid, map-table snapshot, free-list head and dep mask (the slots live when it was allocated).
REQ-008 A resolution SHALL be accepted only when br_state_i is correct or wrong and br_tag_i selects a valid slot; otherwise all resolution outputs are 0 and no state changes.
REQ-009 Accepted correct: the slot's valid bit and that bit in every slot's dep mask SHALL clear at the next edge.
REQ-010 Accepted wrong: every slot whose dep mask contains the resolved bit, plus the resolved slot, SHALL be invalidated at the next edge; squash_mask_o reports that set combinationally in the same cycle.
REQ-011 Accepted wrong: rc_mt_data_o and rc_fl_head_o SHALL present the resolved slot's snapshot combinationally in the same cycle; otherwise both are 0.
REQ-012 Dispatch SHALL allocate the lowest-index slot free after this cycle's correct-resolution clear; snapshot, head and dep mask (the post-clear live mask) are written at the next edge; br_tag_o is asserted combinationally.
REQ-013 Dispatch SHALL be ignored (br_tag_o=0) when no slot is free or an accepted wrong resolution occurs in the same cycle.
REQ-014 full_o SHALL equal AND of the post-resolution valid bits, so a full stack with a same-cycle correct resolution accepts the dispatch.
REQ-015 br_mask_o SHALL equal the registered valid vector (zero-latency view of the state, not of same-cycle updates).
REQ-016 A multi-hot br_tag_i SHALL be illegal; the bench asserts against it.

Reset
REQ-017 While rst_n=0, all valid bits and dep masks SHALL be 0, so br_mask_o=0 and full_o=0; snapshots need not reset. Reset during a resolution or dispatch cycle discards both.

Configuration
REQ-018 With BR_STACK_CNT_EN defined, the block SHALL add output br_free_cnt_o, width $clog2(BR_DEPTH+1). It is a registered count of free slots: reset value BR_DEPTH, updated each edge. Without the macro, the port and its counter are absent and behaviour is otherwise identical.

Verification
REQ-019 Reset, then 4 dispatches: br_tag_o=0001,0010,0100,1000; br_mask_o ends 1111; full_o=1; a 5th dispatch gives br_tag_o=0.
REQ-020 Full stack, correct on 0010 plus dispatch in the same cycle: br_bit_o=0010, br_tag_o=0010, and the new slot's dep mask is 1101.
REQ-021 Slots 0..3 allocated in order, wrong on 0010: squash_mask_o=1110; rc outputs equal slot 1's snapshot; next cycle br_mask_o=0001.
REQ-022 Wrong resolution plus dispatch in the same cycle: br_tag_o=0; no slot is allocated.
REQ-023 Resolution on an unallocated slot (br_mask_o=0001, br_tag_i=0100, wrong): br_bit_o=0, squash_mask_o=0, rc outputs 0, state unchanged.
REQ-024 With BR_STACK_CNT_EN: 3 dispatches, then 1 correct resolution, gives br_free_cnt_o sequence 4,3,2,1,2; async reset mid-sequence immediately gives 4.
